// File: rtl/out_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : out_stream_fifo
// Purpose  : Output stream buffer for the convolution engine. A one-entry
//            stage register holds each result word until its tlast value is
//            known, then the word goes into a DEPTH-entry FIFO whose head is
//            held in a registered read stage driving an AXI4-Stream master.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_data/in_valid  - result words (no backpressure to source)
//            in_done           - one-cycle end-of-frame pulse
//            m_axis_*          - AXI4-Stream master (tkeep fixed 8'hFF)
//            almost_full       - registered, free entries <= AF_MARGIN
//            overflow          - sticky, a word was dropped on a full FIFO
//            level             - FIFO occupancy, 0..DEPTH (stage excluded)
//            beat_count        - beats popped in the current frame
//            drop_count        - words dropped
// Options  : OUT_FIFO_STATS_EN - when defined, beat_count/drop_count are
//            live saturating counters; otherwise both are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module out_stream_fifo #(
   parameter int DEPTH     = 512,
   parameter int AF_MARGIN = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [63:0]            in_data,
   input  logic                   in_valid,
   input  logic                   in_done,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [63:0]            m_axis_tdata,
   output logic [7:0]             m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   almost_full,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] level,
   output logic [31:0]            beat_count,
   output logic [31:0]            drop_count
);

   localparam int              c_AW         = $clog2(DEPTH);
   localparam int              c_LW         = c_AW + 1;
   localparam logic [c_LW-1:0] c_FULL_LEVEL = c_LW'(DEPTH);
   localparam logic [c_LW-1:0] c_AF_LEVEL   = c_LW'(DEPTH - AF_MARGIN);

   // ------------------------------------------------------------------
   // Stage register
   // ------------------------------------------------------------------
   logic        stage_v_q,    stage_v_d;
   logic [63:0] stage_data_q, stage_data_d;
   logic        stage_last_q, stage_last_d;

   logic        w_push;
   logic        w_push_last;
   logic [63:0] w_push_data;

   always_comb begin
      stage_v_d    = stage_v_q;
      stage_data_d = stage_data_q;
      stage_last_d = stage_last_q;
      w_push       = 1'b0;
      w_push_last  = 1'b0;
      w_push_data  = stage_data_q;

      if (stage_v_q && stage_last_q) begin
         // Frame end already known: retire the staged word as the tlast
         // beat. A word arriving now starts the next frame; it only gets
         // last=1 if its own in_done arrives with it.
         w_push       = 1'b1;
         w_push_last  = 1'b1;
         stage_v_d    = in_valid;
         stage_last_d = in_valid && in_done;
         if (in_valid) begin
            stage_data_d = in_data;
         end
      end else if (in_valid) begin
         // A newer word proves the staged one is not the last of its frame.
         w_push       = stage_v_q;
         stage_v_d    = 1'b1;
         stage_data_d = in_data;
         stage_last_d = in_done;
      end else if (in_done && stage_v_q) begin
         w_push       = 1'b1;
         w_push_last  = 1'b1;
         stage_v_d    = 1'b0;
         stage_last_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // FIFO: memory plus a registered head (out_*). level counts both.
   // ------------------------------------------------------------------
   logic [64:0]      mem_q [DEPTH];
   logic [c_AW-1:0]  wr_ptr_q,   wr_ptr_d;
   logic [c_AW-1:0]  rd_ptr_q,   rd_ptr_d;
   logic [c_LW-1:0]  level_q,    level_d;
   logic             out_v_q,    out_v_d;
   logic [63:0]      out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic             af_q,       af_d;
   logic             ovf_q,      ovf_d;

   logic             w_pop;
   logic             w_full;
   logic             w_push_ok;
   logic             w_drop;
   logic             w_mem_has;
   logic             w_mem_we;
   logic [64:0]      w_mem_rd;

   assign w_pop     = out_v_q && m_axis_tready;
   assign w_full    = (level_q == c_FULL_LEVEL);
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;
   // Memory never holds more than DEPTH-1 words (the head sits in out_*),
   // so equal pointers unambiguously mean the memory is empty.
   assign w_mem_has = (wr_ptr_q != rd_ptr_q);
   assign w_mem_rd  = mem_q[rd_ptr_q];

   always_comb begin
      out_v_d    = out_v_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      rd_ptr_d   = rd_ptr_q;
      w_mem_we   = w_push_ok;

      if (!out_v_q || w_pop) begin
         if (w_mem_has) begin
            out_v_d    = 1'b1;
            out_data_d = w_mem_rd[63:0];
            out_last_d = w_mem_rd[64];
            rd_ptr_d   = rd_ptr_q + c_AW'(1);
         end else if (w_push_ok) begin
            // Empty FIFO: bypass the memory so a word reaches the bus the
            // cycle after it leaves the stage.
            out_v_d    = 1'b1;
            out_data_d = w_push_data;
            out_last_d = w_push_last;
            w_mem_we   = 1'b0;
         end else begin
            out_v_d    = 1'b0;
         end
      end

      wr_ptr_d = w_mem_we ? (wr_ptr_q + c_AW'(1)) : wr_ptr_q;
      level_d  = level_q + c_LW'(w_push_ok) - c_LW'(w_pop);
      af_d     = (level_d >= c_AF_LEVEL);
      ovf_d    = ovf_q || w_drop;
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[wr_ptr_q] <= {w_push_last, w_push_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_v_q    <= 1'b0;
         stage_data_q <= '0;
         stage_last_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         out_v_q      <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         af_q         <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         stage_v_q    <= stage_v_d;
         stage_data_q <= stage_data_d;
         stage_last_q <= stage_last_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         out_v_q      <= out_v_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         af_q         <= af_d;
         ovf_q        <= ovf_d;
      end
   end

   assign m_axis_tvalid = out_v_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tkeep  = 8'hFF;
   assign almost_full   = af_q;
   assign overflow      = ovf_q;
   assign level         = level_q;

   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
`ifdef OUT_FIFO_STATS_EN
   logic [31:0] beat_cnt_q, beat_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (w_pop) begin
         // The tlast pop closes the frame; the next cycle reads zero.
         if (out_last_q) begin
            beat_cnt_d = '0;
         end else if (beat_cnt_q != 32'hFFFF_FFFF) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
         end
      end
      if (w_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign beat_count = beat_cnt_q;
   assign drop_count = drop_cnt_q;
`else
   assign beat_count = 32'd0;
   assign drop_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_stream_fifo
// Purpose  : Self-checking bench for out_stream_fifo (DEPTH=16, AF_MARGIN=4).
//            Stimulus pushes expected beats into a scoreboard queue from a
//            frame-level model; a monitor pops and compares on each handshake
//            and checks that a stalled beat holds steady.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_stream_fifo;

   localparam int DEPTH     = 16;
   localparam int AF_MARGIN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_done;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        almost_full;
   logic        overflow;
   logic [4:0]  level;
   logic [31:0] beat_count;
   logic [31:0] drop_count;

   out_stream_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_done(in_done),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast),
      .almost_full(almost_full), .overflow(overflow), .level(level),
      .beat_count(beat_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          total = 0;
   int          bad   = 0;
   logic [64:0] exp_q[$];
   logic        fixed_ready = 1'b0;
   logic        rand_ready  = 1'b0;
   int          beat_seen = 0;
   int          last_seen = 0;
   int          first_valid_cyc = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
   endtask

   task automatic send_word(input logic [63:0] d, input logic done);
      in_valid = 1'b1;
      in_data  = d;
      in_done  = done;
      cycle();
      in_valid = 1'b0;
      in_done  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && n < 4000) begin
         cycle();
         n++;
      end
      chk({name, "_drain_in_time"}, 64'(n < 4000), 64'd1);
      repeat (4) cycle();
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   logic        m_stall = 1'b0;
   logic [63:0] m_hold_data;
   logic        m_hold_last;
   logic [64:0] m_exp;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_stall = 1'b0;
         end else begin
            if (m_stall) begin
               chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
               chk("stall_data", m_axis_tdata, m_hold_data);
               chk("stall_last", 64'(m_axis_tlast), 64'(m_hold_last));
            end
            if (m_axis_tvalid) begin
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               if (m_axis_tready) begin
                  beat_seen++;
                  if (m_axis_tlast) last_seen++;
                  chk("tkeep", 64'(m_axis_tkeep), 64'hFF);
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL beat_unexpected: actual data=%0h last=%0b required=no beat",
                              m_axis_tdata, m_axis_tlast);
                  end else begin
                     m_exp = exp_q.pop_front();
                     chk("beat_data", m_axis_tdata, m_exp[63:0]);
                     chk("beat_last", 64'(m_axis_tlast), 64'(m_exp[64]));
                  end
                  m_stall = 1'b0;
               end else begin
                  m_stall     = 1'b1;
                  m_hold_data = m_axis_tdata;
                  m_hold_last = m_axis_tlast;
               end
            end else begin
               m_stall = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
      chk({tag, "_tdata"}, m_axis_tdata, 64'd0);
      chk({tag, "_level"}, 64'(level), 64'd0);
      chk({tag, "_almost_full"}, 64'(almost_full), 64'd0);
      chk({tag, "_overflow"}, 64'(overflow), 64'd0);
      chk({tag, "_beat_count"}, 64'(beat_count), 64'd0);
      chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int b0;
      int l0;
      int w1;
      int acc;
      int drops;
      int n;
      int sent;
      logic [63:0] d;

      rst = 1'b1; in_data = '0; in_valid = 1'b0; in_done = 1'b0; m_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst = 1'b0;

      // Frame of 8 words 1..8, in_done with word 8, sink always ready.
      fixed_ready = 1'b1;
      cycle();
      first_valid_cyc = -1;
      b0 = beat_seen; l0 = last_seen;
      w1 = cyc;
      for (int i = 1; i <= 8; i++) begin
         exp_q.push_back({(i == 8), 64'(i)});
         send_word(64'(i), (i == 8));
      end
      wait_drain("frame8");
      chk("frame8_latency", 64'(first_valid_cyc - w1), 64'd2);
      chk("frame8_beats", 64'(beat_seen - b0), 64'd8);
      chk("frame8_tlasts", 64'(last_seen - l0), 64'd1);

      // Frame of 4 words, in_done arrives 3 cycles after the 4th word.
      b0 = beat_seen; l0 = last_seen;
      for (int i = 0; i < 4; i++) begin
         d = {$urandom, $urandom};
         exp_q.push_back({(i == 3), d});
         send_word(d, 1'b0);
      end
      cycle();
      cycle();
      in_done = 1'b1;
      cycle();
      in_done = 1'b0;
      wait_drain("late_done");
      chk("late_done_beats", 64'(beat_seen - b0), 64'd4);
      chk("late_done_tlasts", 64'(last_seen - l0), 64'd1);

      // in_done with nothing pending.
      b0 = beat_seen;
      in_done = 1'b1;
      cycle();
      in_done = 1'b0;
      repeat (5) cycle();
      chk("idle_done_beats", 64'(beat_seen - b0), 64'd0);
      chk("idle_done_level", 64'(level), 64'd0);
      chk("idle_done_overflow", 64'(overflow), 64'd0);
      chk("idle_done_drop_count", 64'(drop_count), 64'd0);
      chk("idle_done_beat_count", 64'(beat_count), 64'd0);

      // Overflow: sink stalled, 18-word frame into a 16-entry FIFO.
      fixed_ready = 1'b0;
      cycle();
      b0 = beat_seen; l0 = last_seen;
      acc = 0; drops = 0;
      for (int i = 1; i <= 18; i++) begin
         d = {$urandom, $urandom};
         if (acc < DEPTH) begin
            exp_q.push_back({(i == 18), d});
            acc++;
         end else begin
            drops++;
         end
         send_word(d, (i == 18));
      end
      repeat (4) cycle();
      chk("ovf_level", 64'(level), 64'(DEPTH));
      chk("ovf_overflow", 64'(overflow), 64'd1);
      chk("ovf_almost_full", 64'(almost_full), 64'd1);
      chk("ovf_tvalid", 64'(m_axis_tvalid), 64'd1);
`ifdef OUT_FIFO_STATS_EN
      chk("ovf_drop_count", 64'(drop_count), 64'(drops));
`else
      chk("ovf_drop_count", 64'(drop_count), 64'd0);
`endif
      fixed_ready = 1'b1;
      wait_drain("ovf");
      chk("ovf_beats", 64'(beat_seen - b0), 64'(acc));
      chk("ovf_tlasts", 64'(last_seen - l0), 64'd0);
      chk("ovf_sticky", 64'(overflow), 64'd1);
`ifdef OUT_FIFO_STATS_EN
      chk("ovf_beat_count", 64'(beat_count), 64'(acc));
`else
      chk("ovf_beat_count", 64'(beat_count), 64'd0);
`endif

      // Reset in the middle of a 10-word frame, then a fresh 3-word frame.
      fixed_ready = 1'b0;
      cycle();
      for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b0);
      rst = 1'b1;
      cycle();
      chk_reset_state("midrst");
      rst = 1'b0;
      fixed_ready = 1'b1;
      cycle();
      b0 = beat_seen; l0 = last_seen;
      for (int i = 0; i < 3; i++) begin
         d = {$urandom, $urandom};
         exp_q.push_back({(i == 2), d});
         send_word(d, (i == 2));
      end
      wait_drain("post_rst");
      chk("post_rst_beats", 64'(beat_seen - b0), 64'd3);
      chk("post_rst_tlasts", 64'(last_seen - l0), 64'd1);

      // 1000 random words, random sink, input throttled by almost_full.
      rand_ready = 1'b1;
      cycle();
      b0 = beat_seen; l0 = last_seen;
      sent = 0; n = 0;
      while (sent < 1000 && n < 20000) begin
         if (!almost_full && ($urandom_range(0, 1) == 1)) begin
            d = {$urandom, $urandom};
            exp_q.push_back({(sent == 999), d});
            in_valid = 1'b1;
            in_data  = d;
            in_done  = (sent == 999);
            sent++;
         end else begin
            in_valid = 1'b0;
            in_done  = 1'b0;
         end
         cycle();
         n++;
      end
      in_valid = 1'b0;
      in_done  = 1'b0;
      chk("rand_all_sent", 64'(sent), 64'd1000);
      wait_drain("rand");
      chk("rand_beats", 64'(beat_seen - b0), 64'd1000);
      chk("rand_tlasts", 64'(last_seen - l0), 64'd1);
      chk("rand_overflow", 64'(overflow), 64'd0);
      chk("rand_level", 64'(level), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
